// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: requests to send, then shifts one command byte
// out on the device-generated clock and reports the device acknowledge.
module ps2_host_tx #(
    parameter int INHIBIT_CYCLES = 5000,
    parameter int TIMEOUT_CYCLES = 750000
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic       ps2_clk_low,
    output logic       ps2_data_low,
    input  logic [7:0] tx_data,
    input  logic       tx_start,
    output logic       busy,
    output logic       done,
    output logic       ack_err
);

    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int INH_W = $clog2(INHIBIT_CYCLES + 1);
    localparam logic [INH_W-1:0] INH_LOAD = INH_W'(INHIBIT_CYCLES - 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_INHIBIT,
        S_REQ,
        S_SEND,
        S_ACK,
        S_WAITREL,
        S_FIN
    } state_t;

    state_t           state_q, state_d;
    logic [2:0]       sync_q, sync_d;
    logic [1:0]       dsync_q, dsync_d;
    logic [7:0]       d_q, d_d;
    logic [3:0]       bitcnt_q, bitcnt_d;
    logic [INH_W-1:0] inh_cnt_q, inh_cnt_d;
    logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
    logic             clk_low_q, clk_low_d;
    logic             data_low_q, data_low_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             ack_err_q, ack_err_d;

    logic       fall;
    logic       clk_s;
    logic       data_s;
    logic       to_hit;
    logic [9:0] frame;

    assign fall   = sync_q[2] & ~sync_q[1];
    assign clk_s  = sync_q[1];
    assign data_s = dsync_q[1];
    assign to_hit = (to_cnt_q == TO_LAST);
    // Bit 9 is the stop bit (released), bit 8 odd parity, bits 7..0 the byte LSB first.
    assign frame  = {1'b1, ~^d_q, d_q};

    // NOTE: every variable gets its hold value first, so no path through the case leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        sync_d     = {sync_q[1:0], ps2_clk};
        dsync_d    = {dsync_q[0], ps2_data};
        d_d        = d_q;
        bitcnt_d   = bitcnt_q;
        inh_cnt_d  = inh_cnt_q;
        to_cnt_d   = to_cnt_q;
        clk_low_d  = clk_low_q;
        data_low_d = data_low_q;
        ack_err_d  = ack_err_q;

        case (state_q)
            S_IDLE: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                if (tx_start) begin
                    d_d       = tx_data;
                    inh_cnt_d = INH_LOAD;
                    ack_err_d = 1'b0;
                    clk_low_d = 1'b1;
                    state_d   = S_INHIBIT;
                end
            end
            S_INHIBIT: begin
                if (inh_cnt_q == '0) begin
                    data_low_d = 1'b1;
                    state_d    = S_REQ;
                end else begin
                    inh_cnt_d = inh_cnt_q - 1'b1;
                end
            end
            S_REQ: begin
                // Data stays low: that is the start bit the device sees once the clock is released.
                clk_low_d = 1'b0;
                bitcnt_d  = 4'd0;
                to_cnt_d  = '0;
                state_d   = S_SEND;
            end
            S_SEND: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_hit) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b0;
                    ack_err_d  = 1'b1;
                    state_d    = S_FIN;
                end else if (fall) begin
                    data_low_d = ~frame[bitcnt_q];
                    bitcnt_d   = bitcnt_q + 4'd1;
                    if (bitcnt_q == 4'd9) begin
                        state_d = S_ACK;
                    end
                end
            end
            S_ACK: begin
                to_cnt_d   = to_cnt_q + 1'b1;
                data_low_d = 1'b0;
                if (to_hit) begin
                    clk_low_d = 1'b0;
                    ack_err_d = 1'b1;
                    state_d   = S_FIN;
                end else if (fall) begin
                    ack_err_d = data_s;
                    state_d   = S_WAITREL;
                end
            end
            S_WAITREL: begin
                to_cnt_d = to_cnt_q + 1'b1;
                if (to_hit) begin
                    clk_low_d  = 1'b0;
                    data_low_d = 1'b0;
                    ack_err_d  = 1'b1;
                    state_d    = S_FIN;
                end else if (clk_s && data_s) begin
                    state_d = S_FIN;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                clk_low_d  = 1'b0;
                data_low_d = 1'b0;
                state_d    = S_IDLE;
            end
        endcase

        done_d = (state_d == S_FIN);
        busy_d = (state_d != S_IDLE);
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (clr) begin
            state_q    <= S_IDLE;
            sync_q     <= 3'b111;
            dsync_q    <= 2'b11;
            bitcnt_q   <= 4'd0;
            inh_cnt_q  <= '0;
            to_cnt_q   <= '0;
            clk_low_q  <= 1'b0;
            data_low_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            ack_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            sync_q     <= sync_d;
            dsync_q    <= dsync_d;
            bitcnt_q   <= bitcnt_d;
            inh_cnt_q  <= inh_cnt_d;
            to_cnt_q   <= to_cnt_d;
            clk_low_q  <= clk_low_d;
            data_low_q <= data_low_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            ack_err_q  <= ack_err_d;
        end
    end

    // NOTE: the byte register is left out of reset; it is always loaded on acceptance before it is read.
    always_ff @(posedge clk) begin
        d_q <= d_d;
    end

    assign ps2_clk_low  = clk_low_q;
    assign ps2_data_low = data_low_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign ack_err      = ack_err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: a behavioural PS/2 device on wired-AND lines, checked
// against an arithmetic frame model (byte LSB first, odd parity, stop).
module tb_ps2_host_tx;

    localparam int INH  = 20;
    localparam int TO   = 4000;
    localparam int HALF = 40;

    logic       clk = 1'b0;
    logic       clr = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_start = 1'b0;
    logic       dev_clk_low = 1'b0;
    logic       dev_data_low = 1'b0;
    logic       ps2_clk_low, ps2_data_low, busy, done, ack_err;
    logic       line_clk, line_data;

    int n_asserts = 0;
    int n_fail    = 0;
    int done_cnt  = 0;

    assign line_clk  = ~(ps2_clk_low | dev_clk_low);
    assign line_data = ~(ps2_data_low | dev_data_low);

    ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO)) dut (
        .clk         (clk),
        .clr         (clr),
        .ps2_clk     (line_clk),
        .ps2_data    (line_data),
        .ps2_clk_low (ps2_clk_low),
        .ps2_data_low(ps2_data_low),
        .tx_data     (tx_data),
        .tx_start    (tx_start),
        .busy        (busy),
        .done        (done),
        .ack_err     (ack_err)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #2000000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Odd parity from a population count, independent of any XOR reduction.
    function automatic logic ref_parity(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        return (ones % 2) == 0;
    endfunction

    // Device side: 10 data clocks sampling on the rising edge, then an 11th clock for the ack.
    task automatic dev_xfer(input bit give_ack, input int inj_k, input int clr_k,
                            output logic [7:0] got, output logic par, output logic stp,
                            output bit aborted);
        logic b;
        got = 8'h00; par = 1'b0; stp = 1'b0; aborted = 1'b0;
        repeat (10) tick();
        for (int k = 0; k < 10; k++) begin
            if (k == inj_k) begin
                tx_data  = 8'h00;
                tx_start = 1'b1;
                tick();
                tx_start = 1'b0;
            end
            dev_clk_low = 1'b1;
            repeat (HALF) tick();
            if (k == clr_k) begin
                aborted = 1'b1;
                return;
            end
            b = line_data;
            dev_clk_low = 1'b0;
            if (k < 8) got[k] = b;
            else if (k == 8) par = b;
            else stp = b;
            repeat (HALF) tick();
        end
        dev_data_low = give_ack;
        repeat (5) tick();
        dev_clk_low = 1'b1;
        repeat (HALF) tick();
        dev_clk_low  = 1'b0;
        dev_data_low = 1'b0;
    endtask

    task automatic start_req(input logic [7:0] b, input string tag);
        int n;
        tx_data  = b;
        tx_start = 1'b1;
        tick();
        tx_start = 1'b0;
        check({tag, "_accept_busy"}, busy, 1);
        check({tag, "_accept_clk_low"}, ps2_clk_low, 1);
        n = 0;
        while (ps2_clk_low && !ps2_data_low && n < 100) begin
            n++;
            tick();
        end
        check({tag, "_inhibit_len"}, n, INH);
        check({tag, "_req_both_low"}, {ps2_clk_low, ps2_data_low}, 2'b11);
        tick();
        check({tag, "_release_start_bit"}, {ps2_clk_low, line_data}, 2'b00);
    endtask

    task automatic xfer(input logic [7:0] b, input bit give_ack, input int inj_k, input string tag);
        logic [7:0] got;
        logic       par, stp, prev_busy;
        bit         ab;
        int         n;
        start_req(b, tag);
        dev_xfer(give_ack, inj_k, -1, got, par, stp, ab);
        check({tag, "_byte"}, got, b);
        check({tag, "_parity"}, par, ref_parity(b));
        check({tag, "_stop"}, stp, 1);
        n = 0;
        prev_busy = busy;
        while (!done && n < 300) begin
            prev_busy = busy;
            tick();
            n++;
        end
        check({tag, "_done_seen"}, done, 1);
        check({tag, "_busy_before_done"}, prev_busy, 1);
        check({tag, "_ack_err"}, ack_err, !give_ack);
        tick();
        check({tag, "_after_done"}, {done, busy, ps2_clk_low, ps2_data_low}, 4'b0000);
        check({tag, "_ack_err_hold"}, ack_err, !give_ack);
    endtask

    initial begin
        logic [7:0] b, got;
        logic       par, stp;
        bit         ab, ack;
        int         n, d0;

        repeat (3) tick();
        check("reset_outputs", {ps2_clk_low, ps2_data_low, busy, done, ack_err}, 5'b00000);
        clr = 1'b0;
        repeat (3) tick();
        check("idle_outputs", {ps2_clk_low, ps2_data_low, busy, done, ack_err}, 5'b00000);

        xfer(8'hED, 1'b1, -1, "ed_ack");
        xfer(8'hF4, 1'b1, -1, "f4_ack");
        xfer(8'h3C, 1'b0, -1, "no_ack");

        // Device silent after release: timeout counted from the release edge.
        start_req(8'h5A, "timeout");
        n = 0;
        while (!done && n < 5000) begin
            tick();
            n++;
        end
        check("timeout_cycles", n, TO);
        check("timeout_ack_err", ack_err, 1);
        check("timeout_drives", {ps2_clk_low, ps2_data_low}, 2'b00);
        tick();
        check("timeout_after", {done, busy}, 2'b00);

        // tx_start of 0x00 while busy must not disturb the 0xFF frame.
        xfer(8'hFF, 1'b1, 3, "busy_ignore");

        // Reset during bit 4 (a 0 bit, so data is actively pulled low).
        b = 8'($urandom) & 8'hEF;
        start_req(b, "clr_mid");
        dev_xfer(1'b1, -1, 4, got, par, stp, ab);
        check("clr_mid_aborted", ab, 1);
        check("clr_mid_bit4_driven", ps2_data_low, 1);
        d0 = done_cnt;
        clr = 1'b1;
        tick();
        check("clr_mid_released", {ps2_clk_low, ps2_data_low, busy, done}, 4'b0000);
        clr = 1'b0;
        dev_clk_low = 1'b0;
        repeat (100) tick();
        check("clr_mid_no_done", done_cnt, d0);
        xfer(8'($urandom), 1'b1, -1, "after_clr");

        for (int i = 0; i < 3; i++) begin
            b   = 8'($urandom);
            ack = 1'($urandom_range(0, 1));
            xfer(b, ack, -1, "rand");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
